// File: rtl/multi_anchor_vertex_if.sv
// Anchor-set request and vertex-result handshake shared by the resolver and its
// front end: the front end is master, the resolver is slave.
interface multi_anchor_vertex_if #(
  parameter int N = 8,
  parameter int M = 4
);
  localparam int VW = $clog2(M - 1);

  logic                   in_valid;
  logic                   in_ready;
  logic                   in_mode;
  logic [M*N-1:0]         anc_x;
  logic [M*N-1:0]         anc_y;
  logic [M*(N+1)-1:0]     anc_r;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [N+1:0]    xT;
  logic signed [N+1:0]    yT;
  logic [VW-1:0]          votes;
  logic                   unanimous;

  modport master (
    output in_valid, in_mode, anc_x, anc_y, anc_r, out_ready,
    input  in_ready, out_valid, xT, yT, votes, unanimous
  );

  modport slave (
    input  in_valid, in_mode, anc_x, anc_y, anc_r, out_ready,
    output in_ready, out_valid, xT, yT, votes, unanimous
  );
endinterface

// File: rtl/multi_anchor_vertex.sv
// Sequential trilateration vertex resolver: intersects anchors 0/1 once, then
// lets anchors 2..M-1 vote on P2, one anchor per cycle.
module multi_anchor_vertex #(
  parameter int N = 8,
  parameter int M = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  multi_anchor_vertex_if.slave bus
);
  localparam int VW = $clog2(M - 1);
  localparam int KW = $clog2(M);

  typedef enum logic [1:0] {IDLE, ISECT, VOTE, DONE} state_t;
  state_t state_reg, state_next;

  logic signed [N-1:0] ax_reg [M];
  logic signed [N-1:0] ay_reg [M];
  logic signed [N:0]   ar_reg [M];
  logic                mode_reg;
  logic [KW-1:0]       k_reg;
  logic [VW-1:0]       vote_reg, vote_next, votes_reg;
  logic signed [N+1:0] p1x_reg, p1y_reg, p2x_reg, p2y_reg;
  logic signed [N+1:0] xt_reg, yt_reg;
  logic                unan_reg;

  logic                accept, last_anchor, in_range, all_agree, sel_p2;
  logic signed [N+1:0] i1x, i1y, i2x, i2y;

  assign accept = bus.in_valid && (state_reg == IDLE);

  for (genvar gi = 0; gi < M; gi++) begin : gen_anchor
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ax_reg[gi] <= '0;
        ay_reg[gi] <= '0;
        ar_reg[gi] <= '0;
      end else if (accept) begin
        ax_reg[gi] <= bus.anc_x[gi*N +: N];
        ay_reg[gi] <= bus.anc_y[gi*N +: N];
        ar_reg[gi] <= bus.anc_r[gi*(N+1) +: N+1];
      end
    end
  end

  intersections_comb #(.N(N)) u_isect (
    .x0(ax_reg[0]), .y0(ay_reg[0]), .r0(ar_reg[0]),
    .x1(ax_reg[1]), .y1(ay_reg[1]), .r1(ar_reg[1]),
    .x1P(i1x), .y1P(i1y), .x2P(i2x), .y2P(i2y)
  );

  inside_ #(.N(N)) u_inside (
    .px(p2x_reg), .py(p2y_reg),
    .cx(ax_reg[k_reg]), .cy(ay_reg[k_reg]), .r(ar_reg[k_reg]),
    .in_range(in_range)
  );

  // The final vote lands in the same cycle as the decision, so select on vote_next.
  assign vote_next   = vote_reg + VW'(in_range);
  assign last_anchor = (k_reg == KW'(M - 1));
  assign all_agree   = (vote_next == VW'(M - 2));
  assign sel_p2      = mode_reg ? all_agree : ({vote_next, 1'b0} > (VW+1)'(M - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = ISECT;
      end
      ISECT: state_next = VOTE;
      VOTE:  if (last_anchor) state_next = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg  <= 1'b0;
      k_reg     <= '0;
      vote_reg  <= '0;
      p1x_reg   <= '0;
      p1y_reg   <= '0;
      p2x_reg   <= '0;
      p2y_reg   <= '0;
      xt_reg    <= '0;
      yt_reg    <= '0;
      votes_reg <= '0;
      unan_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          mode_reg <= bus.in_mode;
          k_reg    <= '0;
          vote_reg <= '0;
        end
        ISECT: begin
          p1x_reg <= i1x;
          p1y_reg <= i1y;
          p2x_reg <= i2x;
          p2y_reg <= i2y;
          k_reg   <= KW'(2);
        end
        VOTE: begin
          vote_reg <= vote_next;
          if (last_anchor) begin
            xt_reg    <= sel_p2 ? p2x_reg : p1x_reg;
            yt_reg    <= sel_p2 ? p2y_reg : p1y_reg;
            votes_reg <= vote_next;
            unan_reg  <= all_agree;
          end else begin
            k_reg <= k_reg + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.xT        = xt_reg;
  assign bus.yT        = yt_reg;
  assign bus.votes     = votes_reg;
  assign bus.unanimous = unan_reg;
endmodule

// Integer two-circle intersection: chord midpoint at distance a along the centre
// line, offset by +-h perpendicular. Divisions truncate toward zero.
module intersections_comb #(
  parameter int N = 8
) (
  input  logic signed [N-1:0] x0, y0, x1, y1,
  input  logic signed [N:0]   r0, r1,
  output logic signed [N+1:0] x1P, y1P, x2P, y2P
);
  localparam int IW = 4*N + 8;

  function automatic logic [IW-1:0] isqrt(input logic [IW-1:0] v);
    logic [IW-1:0] num, res, bitv;
    num  = v;
    res  = '0;
    bitv = '0;
    bitv[IW-2] = 1'b1;
    for (int i = 0; i < IW/2; i++) begin
      if (num >= res + bitv) begin
        num = num - res - bitv;
        res = (res >> 1) + bitv;
      end else begin
        res = res >> 1;
      end
      bitv = bitv >> 2;
    end
    return res;
  endfunction

  logic signed [IW-1:0] dx, dy, d2, d, dd, rr0, rr1, a, h2, h, ox, oy, hx, hy;

  always_comb begin
    dx  = IW'(x1) - IW'(x0);
    dy  = IW'(y1) - IW'(y0);
    d2  = dx*dx + dy*dy;
    d   = isqrt(d2);
    dd  = d;
    if (d == '0) dd = IW'(1);
    rr0 = IW'(r0) * IW'(r0);
    rr1 = IW'(r1) * IW'(r1);
    a   = (rr0 - rr1 + d2) / (dd + dd);
    h2  = rr0 - a*a;
    // Non-intersecting circles clamp the offset to zero (closest-approach point).
    if (h2[IW-1]) h2 = '0;
    h   = isqrt(h2);
    ox  = (a*dx) / dd;
    oy  = (a*dy) / dd;
    hx  = (h*dy) / dd;
    hy  = (h*dx) / dd;
    x1P = (N+2)'(IW'(x0) + ox - hx);
    y1P = (N+2)'(IW'(y0) + oy + hy);
    x2P = (N+2)'(IW'(x0) + ox + hx);
    y2P = (N+2)'(IW'(y0) + oy - hy);
    if (d2 == '0) begin
      x1P = (N+2)'(x0);
      y1P = (N+2)'(y0);
      x2P = (N+2)'(x0);
      y2P = (N+2)'(y0);
    end
  end
endmodule

// Closed-disc containment test: boundary points count as inside.
module inside_ #(
  parameter int N = 8
) (
  input  logic signed [N+1:0] px, py,
  input  logic signed [N-1:0] cx, cy,
  input  logic signed [N:0]   r,
  output logic                in_range
);
  localparam int IW = 2*N + 8;
  logic signed [IW-1:0] ddx, ddy;

  always_comb begin
    ddx      = IW'(px) - IW'(cx);
    ddy      = IW'(py) - IW'(cy);
    in_range = (ddx*ddx + ddy*ddy) <= (IW'(r) * IW'(r));
  end
endmodule

// File: tb/tb_multi_anchor_vertex.sv
// Randomised and directed checks of multi_anchor_vertex (M=4 and M=3 instances)
// against a geometric reference model.
module tb_multi_anchor_vertex;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  multi_anchor_vertex_if #(.N(N), .M(4)) bus4 ();
  multi_anchor_vertex_if #(.N(N), .M(3)) bus3 ();

  multi_anchor_vertex #(.N(N), .M(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  multi_anchor_vertex #(.N(N), .M(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint isqrt_m(input longint v);
    longint r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic longint wrap(input longint v);
    logic signed [N+1:0] t;
    t = v[N+1:0];
    return longint'(t);
  endfunction

  // Two circles meet on the chord perpendicular to the centre line.
  function automatic void circle_pair(input longint x0, y0, r0, x1, y1, r1,
                                      output longint p1x, p1y, p2x, p2y);
    longint dx, dy, d2, d, along, h2, h, mx, my;
    dx = x1 - x0;
    dy = y1 - y0;
    d2 = dx*dx + dy*dy;
    if (d2 == 0) begin
      p1x = x0; p1y = y0; p2x = x0; p2y = y0;
      return;
    end
    d     = isqrt_m(d2);
    along = (r0*r0 - r1*r1 + d2) / (2*d);
    h2    = r0*r0 - along*along;
    h     = (h2 > 0) ? isqrt_m(h2) : 0;
    mx    = x0 + along*dx/d;
    my    = y0 + along*dy/d;
    p1x = wrap(mx - h*dy/d);
    p1y = wrap(my + h*dx/d);
    p2x = wrap(mx + h*dy/d);
    p2y = wrap(my - h*dx/d);
  endfunction

  function automatic bit covers(input longint px, py, cx, cy, r);
    return (px-cx)*(px-cx) + (py-cy)*(py-cy) <= r*r;
  endfunction

  function automatic void expect_vertex(input int m, input bit mode,
                                        input longint ax[4], input longint ay[4], input longint ar[4],
                                        output longint xt, output longint yt,
                                        output longint nv, output longint un);
    longint p1x, p1y, p2x, p2y;
    bit take_p2;
    circle_pair(ax[0], ay[0], ar[0], ax[1], ay[1], ar[1], p1x, p1y, p2x, p2y);
    nv = 0;
    for (int k = 2; k < m; k++) if (covers(p2x, p2y, ax[k], ay[k], ar[k])) nv++;
    un = (nv == m - 2) ? 1 : 0;
    take_p2 = mode ? (nv == m - 2) : (2*nv > m - 2);
    xt = take_p2 ? p2x : p1x;
    yt = take_p2 ? p2y : p1y;
  endfunction

  task automatic drive4(input bit mode, input longint ax[4], input longint ay[4], input longint ar[4]);
    bus4.in_mode = mode;
    for (int k = 0; k < 4; k++) begin
      bus4.anc_x[k*N +: N]       = N'(ax[k]);
      bus4.anc_y[k*N +: N]       = N'(ay[k]);
      bus4.anc_r[k*(N+1) +: N+1] = (N+1)'(ar[k]);
    end
  endtask

  // One full transaction on the M=4 instance, optionally stalling in DONE.
  task automatic run4(input string tag, input bit mode,
                      input longint ax[4], input longint ay[4], input longint ar[4], input int stall,
                      output longint gx, output longint gy, output longint gv, output longint gu);
    longint ex, ey, ev, eu;
    int cyc;
    expect_vertex(4, mode, ax, ay, ar, ex, ey, ev, eu);
    drive4(mode, ax, ay, ar);
    check_eq({tag, ".in_ready"}, longint'(bus4.in_ready), 1);
    bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    cyc = 0;
    while (!bus4.out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({tag, ".latency"}, cyc, 3);
    gx = bus4.xT; gy = bus4.yT; gv = bus4.votes; gu = bus4.unanimous;
    check_eq({tag, ".xT"}, gx, ex);
    check_eq({tag, ".yT"}, gy, ey);
    check_eq({tag, ".votes"}, gv, ev);
    check_eq({tag, ".unanimous"}, gu, eu);
    for (int i = 0; i < stall; i++) begin
      bus4.in_valid = 1'b1;
      bus4.anc_x = 32'($urandom);
      bus4.anc_y = 32'($urandom);
      @(posedge clk); #1;
      check_eq({tag, ".stall_valid"}, longint'(bus4.out_valid), 1);
      check_eq({tag, ".stall_in_ready"}, longint'(bus4.in_ready), 0);
      check_eq({tag, ".stall_xT"}, longint'(bus4.xT), ex);
      check_eq({tag, ".stall_yT"}, longint'(bus4.yT), ey);
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    check_eq({tag, ".release_in_ready"}, longint'(bus4.in_ready), 1);
    check_eq({tag, ".release_valid"}, longint'(bus4.out_valid), 0);
    $display("txn %s mode=%0d xT=%0d yT=%0d votes=%0d unanimous=%0d", tag, mode, gx, gy, gv, gu);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint ax[4], ay[4], ar[4];
    longint bx[4], by[4], br[4];
    longint gx, gy, gv, gu, ex, ey, ev, eu, ex2, ey2;
    longint rx[2], ry[2];
    int acc_t[2];
    int nacc, nres, cyc;
    bit acc;

    bus4.in_valid = 0; bus4.out_ready = 0; bus4.in_mode = 0;
    bus4.anc_x = '0; bus4.anc_y = '0; bus4.anc_r = '0;
    bus3.in_valid = 0; bus3.out_ready = 0; bus3.in_mode = 0;
    bus3.anc_x = '0; bus3.anc_y = '0; bus3.anc_r = '0;

    #2 rst_n = 1'b0;
    #1;
    check_eq("reset.in_ready", longint'(bus4.in_ready), 1);
    check_eq("reset.out_valid", longint'(bus4.out_valid), 0);
    check_eq("reset.xT", longint'(bus4.xT), 0);
    check_eq("reset.yT", longint'(bus4.yT), 0);
    check_eq("reset.votes", longint'(bus4.votes), 0);
    check_eq("reset.unanimous", longint'(bus4.unanimous), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Agreement: P2=(4,-3) lies in both voters.
    ax = '{0, 8, 4, 4}; ay = '{0, 0, -3, -3}; ar = '{5, 5, 1, 2};
    run4("agree", 1'b0, ax, ay, ar, 0, gx, gy, gv, gu);
    check_eq("agree.const_xT", gx, 4);
    check_eq("agree.const_yT", gy, -3);
    check_eq("agree.const_votes", gv, 2);

    // Reset mid-VOTE clears outputs without a clock edge.
    drive4(1'b0, ax, ay, ar);
    bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("midreset.out_valid", longint'(bus4.out_valid), 0);
    check_eq("midreset.in_ready", longint'(bus4.in_ready), 1);
    check_eq("midreset.xT", longint'(bus4.xT), 0);
    check_eq("midreset.yT", longint'(bus4.yT), 0);
    check_eq("midreset.votes", longint'(bus4.votes), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Mode split: one vote of two is a tie, so both modes keep P1=(4,3).
    ax = '{0, 8, 4, 4}; ay = '{0, 0, 3, -3}; ar = '{5, 5, 1, 1};
    run4("split_maj", 1'b0, ax, ay, ar, 0, gx, gy, gv, gu);
    check_eq("split_maj.const_yT", gy, 3);
    check_eq("split_maj.const_votes", gv, 1);
    run4("split_una", 1'b1, ax, ay, ar, 10, gx, gy, gv, gu);
    check_eq("split_una.const_yT", gy, 3);
    check_eq("split_una.const_unanimous", gu, 0);

    ax = '{0, 8, 4, 4}; ay = '{0, 0, -3, -2}; ar = '{5, 5, 1, 1};
    run4("both_maj", 1'b0, ax, ay, ar, 0, gx, gy, gv, gu);
    check_eq("both_maj.const_yT", gy, -3);
    check_eq("both_maj.const_unanimous", gu, 1);
    run4("both_una", 1'b1, ax, ay, ar, 0, gx, gy, gv, gu);
    check_eq("both_una.const_yT", gy, -3);
    check_eq("both_una.const_votes", gv, 2);

    // Back-to-back with in_valid and out_ready held high.
    ax = '{0, 8, 4, 4}; ay = '{0, 0, -3, -3}; ar = '{5, 5, 1, 2};
    bx = '{0, 8, 4, 4}; by = '{0, 0, 3, -3}; br = '{5, 5, 1, 1};
    expect_vertex(4, 1'b0, ax, ay, ar, ex, ey, ev, eu);
    expect_vertex(4, 1'b0, bx, by, br, ex2, ey2, ev, eu);
    acc_t = '{0, 0}; rx = '{0, 0}; ry = '{0, 0};
    nacc = 0; nres = 0;
    drive4(1'b0, ax, ay, ar);
    bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    for (int c = 0; c < 40 && nres < 2; c++) begin
      acc = bus4.in_valid && bus4.in_ready;
      if (bus4.out_valid && bus4.out_ready) begin
        rx[nres] = bus4.xT; ry[nres] = bus4.yT; nres++;
      end
      @(posedge clk); #1;
      if (acc && nacc < 2) begin
        acc_t[nacc] = c; nacc++;
        if (nacc == 1) drive4(1'b0, bx, by, br);
        else bus4.in_valid = 1'b0;
      end
    end
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
    check_eq("b2b.results", nres, 2);
    check_eq("b2b.spacing", acc_t[1] - acc_t[0], 5);
    check_eq("b2b.first_xT", rx[0], ex);
    check_eq("b2b.first_yT", ry[0], ey);
    check_eq("b2b.second_xT", rx[1], ex2);
    check_eq("b2b.second_yT", ry[1], ey2);
    $display("txn b2b first=(%0d,%0d) second=(%0d,%0d) spacing=%0d", rx[0], ry[0], rx[1], ry[1], acc_t[1] - acc_t[0]);

    // Random M=4 sets in both modes.
    for (int v = 0; v < 30; v++) begin
      for (int k = 0; k < 4; k++) begin
        ax[k] = longint'($urandom_range(120)) - 60;
        ay[k] = longint'($urandom_range(120)) - 60;
        ar[k] = longint'($urandom_range(120, 1));
      end
      run4("rand4", 1'($urandom_range(1)), ax, ay, ar, 0, gx, gy, gv, gu);
    end

    // M=3 regression against the three-anchor selection.
    for (int v = 0; v < 200; v++) begin
      for (int k = 0; k < 3; k++) begin
        ax[k] = longint'($urandom_range(120)) - 60;
        ay[k] = longint'($urandom_range(120)) - 60;
        ar[k] = longint'($urandom_range(120, 1));
        bus3.anc_x[k*N +: N]       = N'(ax[k]);
        bus3.anc_y[k*N +: N]       = N'(ay[k]);
        bus3.anc_r[k*(N+1) +: N+1] = (N+1)'(ar[k]);
      end
      ax[3] = 0; ay[3] = 0; ar[3] = 0;
      expect_vertex(3, 1'b0, ax, ay, ar, ex, ey, ev, eu);
      bus3.in_mode  = 1'b0;
      bus3.in_valid = 1'b1;
      @(posedge clk); #1;
      bus3.in_valid = 1'b0;
      cyc = 0;
      while (!bus3.out_valid && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      check_eq("m3.latency", cyc, 2);
      check_eq("m3.xT", longint'(bus3.xT), ex);
      check_eq("m3.yT", longint'(bus3.yT), ey);
      $display("txn m3 #%0d xT=%0d yT=%0d votes=%0d", v, bus3.xT, bus3.yT, bus3.votes);
      bus3.out_ready = 1'b1;
      @(posedge clk); #1;
      bus3.out_ready = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multi_anchor_vertex.md
# multi_anchor_vertex

Sequential, parametrised trilateration vertex resolver for M ≥ 3 anchor circles.
- Computes the two intersection points of anchors 0 and 1 once.
- Tests the second point against each remaining anchor, one anchor per cycle, and counts the anchors that contain it.
- Selects the point by majority or unanimous vote and returns it over a valid/ready handshake.
- Sits between the anchor/range front end and the position filter. It replaces the fixed three-anchor combinational vertex stage wherever more anchors are available.

## Interface
- N, 8: coordinate width. Coordinates are signed N bits, radii signed N+1, results signed N+2.
- M, 4: anchor count, M ≥ 3. The vote counter width is VW = $clog2(M-1).
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  anchor set offered.
- in_ready  out  1  block can accept a set. High only in IDLE.
- in_mode  in  1  0 = majority, 1 = unanimous. Latched on accept.
- anc_x, anc_y  in  M*N  anchor centres. Anchor k occupies bits [k*N +: N].
- anc_r  in  M*(N+1)  anchor radii. Anchor k occupies bits [k*(N+1) +: N+1].
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- xT, yT  out  N+2  selected vertex, signed.
- votes  out  VW  number of anchors 2..M-1 that contain P2.
- unanimous  out  1  votes == M-2.

## Operation
- Instantiates one intersections_comb (N) and one inside_ (N).
- On accept (in_valid & in_ready at a rising edge):
  - register all anchors and in_mode;
  - clear the vote counter and the anchor index k.
- FSM states: IDLE, ISECT, VOTE, DONE.
  - IDLE: in_ready=1. On accept, go to ISECT.
  - ISECT (1 cycle): feed registered anchors 0 and 1 to intersections_comb. Register P1=(x1P,y1P) and P2=(x2P,y2P). Set k=2. Go to VOTE.
  - VOTE (M-2 cycles): drive inside_ with P2 and anchor k. If in_range, votes += 1. If k == M-1, go to DONE; otherwise k += 1.
  - DONE: out_valid=1. Outputs are held stable until out_ready is high at an edge, then go to IDLE.
- Selection, applied at the VOTE→DONE transition:
  - majority mode: select P2 if 2*votes > M-2, otherwise P1;
  - unanimous mode: select P2 only if votes == M-2, otherwise P1.
  - Ties in majority mode select P1.
- With M=3 and majority mode, the result equals the combinational three-anchor selection.
- No arithmetic is done beyond the vote counter. The counter cannot overflow because M-2 ≤ 2^VW - 1.
- P1, P2 and the anchor registers are sign-preserving copies with no truncation.
- in_valid while the block is not in IDLE is ignored; in_ready=0 and nothing is latched.
- Input stimulus changes after accept do not affect the result in flight.

## Timing
- Reset (async assert, sync-free release):
  - state=IDLE;
  - in_ready=1;
  - out_valid=0;
  - xT=yT=0, votes=0, unanimous=0;
  - all internal registers are 0.
- Latency: accept at edge t0 → out_valid high after edge t0+M-1 (ISECT 1 cycle, VOTE M-2 cycles).
- Minimum accept-to-accept interval: M+1 cycles, when out_ready is held at 1. The cycle breakdown is:
  - DONE takes ≥1 cycle;
  - IDLE takes 1 cycle before the next accept.
- out_ready low in DONE: stall indefinitely with outputs unchanged.
- out_valid never drops without a handshake, except on reset.
- xT, yT, votes and unanimous are registered. They change only at the VOTE→DONE edge and otherwise hold their last value, including while in IDLE.
- Reset asserted mid-ISECT or mid-VOTE aborts the computation immediately. No partial result is ever presented.
- out_ready high while out_valid=0 has no effect.

## Test plan
- Reset: assert rst_n=0 mid-VOTE. Outputs go to 0 and in_ready=1 without waiting for a clock edge. Release, and the next accept computes normally.
- Agreement, N=8, M=4, majority:
  - inputs: U=(0,0) r=5, V=(8,0) r=5, W2=(4,-3) r=1, W3=(4,-3) r=2;
  - required: out_valid exactly 3 cycles after accept, {xT,yT}=(4,-3), votes = 2 if (4,-3) is P2 else 0, independent of P1/P2 order.
- Mode split, M=4, same U and V, W2=(4,3) r=1, W3=(4,-3) r=1:
  - majority: votes=1, tie → P1;
  - unanimous: also P1;
  - then make both W2 and W3 contain P2: both modes select P2, votes=2, unanimous=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Outputs are stable, in_ready=0, and a new in_valid is ignored. Release, then complete the handshake; in_ready returns high the following cycle.
- Back-to-back: out_ready=1 and in_valid=1 continuously with two distinct anchor sets. Accepts are spaced M+1=5 cycles apart and both results are correct in order.
- M=3 regression: 200 random in-range triples. xT and yT match the three-anchor combinational selection for every vector.
